// File: rtl/dcm_reset_ctrl.sv
// DCM reset sequencer: pulses the DCM reset, waits for a stable lock, then releases sys_reset.
// Optional saturating retry counter enabled by DCM_RESET_CTRL_RETRY_CNT_EN.
module dcm_reset_ctrl #(
    parameter int unsigned RST_CYCLES    = 3,
    parameter int unsigned LOCK_TIMEOUT  = 65535,
    parameter int unsigned STABLE_CYCLES = 1023
) (
    input  logic       m_clock,
    input  logic       p_reset,
    input  logic       dcm_locked,
    input  logic [7:0] dcm_status,
    output logic       dcm_rst,
    output logic       sys_reset,
    output logic       locked_ok,
    output logic [1:0] state
`ifdef DCM_RESET_CTRL_RETRY_CNT_EN
    ,
    output logic [7:0] retry_cnt
`endif
);

    typedef enum logic [1:0] {
        RST_DCM   = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam logic [15:0] RST_LAST    = 16'(RST_CYCLES - 1);
    localparam logic [15:0] TMO_LAST    = 16'(LOCK_TIMEOUT - 1);
    localparam logic [15:0] STABLE_LAST = 16'(STABLE_CYCLES - 1);

    state_t      state_q;
    state_t      state_d;
    logic [15:0] cnt;
    logic [15:0] cnt_d;
    logic        retry_ev;

    logic        lk_p0;
    logic        lk_s;
    logic        stop_p0;
    logic        stop_s;

    logic        unused_status;
    assign unused_status = ^{dcm_status[7:2], dcm_status[0]};

    // Stage p0 -> s: two-flop synchronizers for the asynchronous DCM outputs
    always_ff @(posedge m_clock) begin
        if (p_reset) begin
            lk_p0   <= 1'b0;
            lk_s    <= 1'b0;
            stop_p0 <= 1'b0;
            stop_s  <= 1'b0;
        end else begin
            lk_p0   <= dcm_locked;
            lk_s    <= lk_p0;
            stop_p0 <= dcm_status[1];
            stop_s  <= stop_p0;
        end
    end

    always_ff @(posedge m_clock) begin
        if (p_reset) begin
            state_q <= RST_DCM;
            cnt     <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt     <= cnt_d;
        end
    end

    // Every limit compare leaves the state before cnt could wrap
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt;
        retry_ev = 1'b0;
        case (state_q)
            RST_DCM: begin
                if (cnt == RST_LAST) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt + 16'd1;
                end
            end
            WAIT_LOCK: begin
                if (stop_s) begin
                    state_d  = RST_DCM;
                    cnt_d    = 16'd0;
                    retry_ev = 1'b1;
                end else if (lk_s) begin
                    state_d = STABLE;
                    cnt_d   = 16'd0;
                end else if (cnt == TMO_LAST) begin
                    state_d  = RST_DCM;
                    cnt_d    = 16'd0;
                    retry_ev = 1'b1;
                end else begin
                    cnt_d = cnt + 16'd1;
                end
            end
            STABLE: begin
                if (stop_s) begin
                    state_d  = RST_DCM;
                    cnt_d    = 16'd0;
                    retry_ev = 1'b1;
                end else if (!lk_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = 16'd0;
                end else if (cnt == STABLE_LAST) begin
                    state_d = RUN;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt + 16'd1;
                end
            end
            RUN: begin
                cnt_d = 16'd0;
                if (stop_s || !lk_s) begin
                    state_d  = RST_DCM;
                    retry_ev = 1'b1;
                end
            end
            default: begin
                state_d = RST_DCM;
                cnt_d   = 16'd0;
            end
        endcase
    end

`ifdef DCM_RESET_CTRL_RETRY_CNT_EN
    always_ff @(posedge m_clock) begin
        if (p_reset) begin
            retry_cnt <= 8'd0;
        end else if (retry_ev && (retry_cnt != 8'hFF)) begin
            retry_cnt <= retry_cnt + 8'd1;
        end
    end
`else
    logic unused_retry;
    assign unused_retry = retry_ev;
`endif

    assign dcm_rst   = (state_q == RST_DCM);
    assign sys_reset = (state_q != RUN);
    assign locked_ok = (state_q == RUN);
    assign state     = state_q;

endmodule
